regfile_wb_arbiter: RTL

Shares the single register-file write port between NUM_SRC writeback sources (ALU, load unit, CSR/misc), using round-robin arbitration and a valid/ready handshake per source. A one-entry registered write stage drives the register file's WriteEn/WriteDir/WriteData. The block also exposes two forwarding lookups so the read side can bypass a write that is staged but not yet committed. It sits between the execute/memory writeback paths and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback source bundle: per-source valid/addr/data with ready back.
// Source i occupies slice [i*W +: W] of each packed field.
interface regfile_wb_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;

  modport master (
    output src_valid,
    output src_addr,
    output src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_addr,
    input  src_data,
    output src_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter with one staged write and forwarding.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (source 0 highest).
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave src,
  input  logic              wb_stall,
  output logic              WriteEn,
  output logic [ADDR_W-1:0] WriteDir,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] fwd_dir1,
  input  logic [ADDR_W-1:0] fwd_dir2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic              r_valid;
  logic [ADDR_W-1:0] r_dir;
  logic [DATA_W-1:0] r_data;
`ifndef WB_ARB_FIXED_PRIO_EN
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_ptr_nxt;
`endif

  logic [ADDR_W-1:0]  w_addr [NUM_SRC];
  logic [DATA_W-1:0]  w_data [NUM_SRC];
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_x0;
  logic [NUM_SRC-1:0] w_ready;
  logic               w_can_load;
  logic               w_gnt_vld;
  logic [PW-1:0]      w_gnt;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_addr[gi] = src.src_addr[gi*ADDR_W +: ADDR_W];
    assign w_data[gi] = src.src_data[gi*DATA_W +: DATA_W];
    assign w_x0[gi]   = src.src_valid[gi] & (w_addr[gi] == '0);
    assign w_elig[gi] = src.src_valid[gi] & (w_addr[gi] != '0);
  end

  assign w_can_load = ~r_valid | ~wb_stall;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      if (!w_gnt_vld && w_elig[k]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PW'(k);
      end
`else
      if (!w_gnt_vld && w_elig[(int'(r_ptr) + k) % NUM_SRC]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PW'((int'(r_ptr) + k) % NUM_SRC);
      end
`endif
    end
  end

  // x0 requests are acked and dropped regardless of stall or arbitration
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ready[i] = rst & (w_x0[i] |
        (w_can_load & w_gnt_vld & (w_gnt == PW'(i))));
    end
  end

  assign src.src_ready = w_ready;

`ifndef WB_ARB_FIXED_PRIO_EN
  assign w_ptr_nxt = (w_gnt == PW'(NUM_SRC - 1)) ? '0 : w_gnt + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_dir   <= '0;
      r_data  <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else if (w_can_load) begin
      if (w_gnt_vld) begin
        r_valid <= 1'b1;
        r_dir   <= w_addr[w_gnt];
        r_data  <= w_data[w_gnt];
`ifndef WB_ARB_FIXED_PRIO_EN
        r_ptr   <= w_ptr_nxt;
`endif
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign WriteEn   = r_valid & ~wb_stall & rst;
  assign WriteDir  = r_dir;
  assign WriteData = r_data;

  assign fwd_hit1  = rst & r_valid & (fwd_dir1 == r_dir) & (fwd_dir1 != '0);
  assign fwd_hit2  = rst & r_valid & (fwd_dir2 == r_dir) & (fwd_dir2 != '0);
  assign fwd_data1 = fwd_hit1 ? r_data : '0;
  assign fwd_data2 = fwd_hit2 ? r_data : '0;
endmodule
